// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide controller: state encoding,
// iterative-unit operation codes and the default BUSY timeout.
package mdu_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_WRITE = 2'd3
   } mdu_state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/mdu_timer.sv
// BUSY-cycle counter: cleared when an operation is launched, counts while
// enabled, flags the cycle on which the TIMEOUT-th BUSY cycle completes.
module mdu_timer
   import mdu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [5:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= 6'd0;
      end else if (en) begin
         count <= count + 6'd1;
      end
   end

   // The current BUSY cycle is the TIMEOUT-th one, so the abort lands on its edge.
   assign expired = en && (count == 6'(TIMEOUT - 1));

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences the shared iterative unit, stalls the
// pipeline while it runs and owns the architectural HI/LO registers.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MultE,
   input  logic        DivE,
   input  logic        MthiE,
   input  logic        MtloE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        UnitDone,
   input  logic [31:0] UnitHi,
   input  logic [31:0] UnitLo,
   output logic        UnitStart,
   output logic        UnitOp,
   output logic [31:0] OpA,
   output logic [31:0] OpB,
   output logic        ALUSel,
   output logic        StallMD,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Err,
   output mdu_state_t  state_dbg
);

   // Unit handshake: UnitStart is a one-cycle request with OpA/OpB/UnitOp
   // stable from START until the next accepted instruction; the unit replies
   // with UnitDone plus UnitHi/UnitLo, and that reply is taken only in BUSY.

   mdu_state_t state, state_n;
   logic       tmr_clr, tmr_en, tmr_expired;
   logic       div_by_zero;

   assign div_by_zero = !MultE && DivE && (SrcBE == 32'd0);
   assign state_dbg   = state;

   mdu_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      UnitStart = 1'b0;
      ALUSel    = 1'b0;
      StallMD   = 1'b0;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      case (state)
         S_IDLE: begin
            StallMD = MultE || DivE;
            if (div_by_zero) begin
               state_n = S_WRITE;
            end else if (MultE || DivE) begin
               state_n = S_START;
               tmr_clr = 1'b1;
            end
         end
         S_START: begin
            UnitStart = 1'b1;
            ALUSel    = 1'b1;
            StallMD   = 1'b1;
            state_n   = S_BUSY;
         end
         S_BUSY: begin
            ALUSel  = 1'b1;
            StallMD = 1'b1;
            tmr_en  = 1'b1;
            if (UnitDone || tmr_expired) begin
               state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            // Stall is released here so the instruction retires; never relaunch.
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         HI     <= 32'd0;
         LO     <= 32'd0;
         OpA    <= 32'd0;
         OpB    <= 32'd0;
         UnitOp <= OP_MULT;
         Err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (MultE || DivE) begin
                  OpA    <= SrcAE;
                  OpB    <= SrcBE;
                  UnitOp <= MultE ? OP_MULT : OP_DIV;
                  if (div_by_zero) begin
                     HI <= SrcAE;
                     LO <= 32'hFFFF_FFFF;
                  end
               end else begin
                  if (MthiE) HI <= SrcAE;
                  if (MtloE) LO <= SrcAE;
               end
            end
            S_BUSY: begin
               // A result arriving on the last permitted cycle beats the abort.
               if (UnitDone) begin
                  HI <= UnitHi;
                  LO <= UnitLo;
               end else if (tmr_expired) begin
                  HI  <= 32'd0;
                  LO  <= 32'd0;
                  Err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
